// File: rtl/mux_sel_scanner.sv
// Scan controller for a 4:1 mux: steps the select across the enabled channels,
// samples z after a settle window and presents the 4-bit result over valid/ready.
module mux_sel_scanner #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] ch_mask,
    input  logic       z,
    input  logic       ready,
    output logic [1:0] s,
    output logic       busy,
    output logic [3:0] data,
    output logic       valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] s_q, s_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] cap_q, cap_d;
    logic [3:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic [2:0] nxt_s;

    // Lowest enabled channel of a non-zero mask.
    function automatic logic [1:0] first_ch(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) begin
                r = 2'(i);
            end
        end
        return r;
    endfunction

    // {found, index} of the next enabled channel strictly above cur.
    function automatic logic [2:0] next_ch(input logic [3:0] m, input logic [1:0] cur);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        cap_d   = cap_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        nxt_s   = next_ch(mask_q, s_q);
        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d = ch_mask;
                    cap_d  = 4'b0000;
                    data_d = 4'b0000;
                    busy_d = 1'b1;
                    cnt_d  = 4'd0;
                    if (ch_mask != 4'b0000) begin
                        s_d     = first_ch(ch_mask);
                        state_d = SETTLE;
                    end else begin
                        s_d     = 2'd0;
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (cnt_q == LAST_CNT) begin
                    cap_d[s_q] = z;
                    cnt_d      = 4'd0;
                    if (nxt_s[2]) begin
                        s_d = nxt_s[1:0];
                    end else begin
                        state_d = DONE;
                        data_d  = cap_d;
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                // An empty mask arrives here with valid low; raise it one edge later.
                if (!valid_q) begin
                    valid_d = 1'b1;
                    data_d  = cap_q;
                end else if (ready) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    s_d     = 2'd0;
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = 2'd0;
                cnt_d   = 4'd0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= 2'd0;
            cnt_q   <= 4'd0;
            mask_q  <= 4'b0000;
            cap_q   <= 4'b0000;
            data_q  <= 4'b0000;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign s     = s_q;
    assign busy  = busy_q;
    assign data  = data_q;
    assign valid = valid_q;

endmodule
